// File: rtl/encoder_8x3_seq.sv
// Sequential priority encoder: serializes the index of every set request bit, lowest first.
// Latency: first beat one cycle after acceptance; k set bits take k+1 cycles (all-zero takes 2).
// Backpressure: out_ready=0 holds the current beat; no new vector is taken until the burst drains.
module encoder_8x3_seq #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none,
    output logic [IDX_W:0]   out_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        NONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] low_bit;
    logic [IDX_W-1:0] low_idx;
    logic             single;

    function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
        logic [IDX_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + {{IDX_W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // Scan from the top so the last hit is the lowest set bit.
    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    assign low_bit = pending & (~pending + WIDTH'(1));
    assign single  = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);

    // Outputs decode only from registered state so consumers see no input-to-output paths.
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state != IDLE);
    assign out_none  = (state == NONE);
    assign out_idx   = (state == SERVE) ? low_idx : '0;
    assign out_last  = (state == NONE) || ((state == SERVE) && single);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            out_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_vec != '0) begin
                            pending <= in_vec;
                            out_cnt <= popcount(in_vec);
                            state   <= SERVE;
                        end else begin
                            out_cnt <= '0;
                            state   <= NONE;
                        end
                    end
                end
                SERVE: begin
                    if (out_ready) begin
                        pending <= pending & ~low_bit;
                        if (single) begin
                            state <= IDLE;
                        end
                    end
                end
                NONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    pending <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_8x3_seq.sv
// Directed bench for encoder_8x3_seq: inputs driven and outputs sampled 1 time unit after posedge.
module tb_encoder_8x3_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_last;
    logic       out_none;
    logic [3:0] out_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    encoder_8x3_seq #(.WIDTH(8), .IDX_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_none  (out_none),
        .out_cnt   (out_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a vector and hold it until accepted (bounded).
    task automatic send(input logic [7:0] v);
        int n;
        in_vec   = v;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("accept_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    // Check one beat per cycle with out_ready held high; exp_idx lists the hand-computed indices.
    task automatic burst(input string tag, input int k, input logic [2:0] exp_idx [8],
                         input logic [3:0] exp_cnt);
        out_ready = 1'b1;
        for (int b = 0; b < k; b++) begin
            chk({tag, "_valid"}, out_valid, 1);
            chk({tag, "_idx"}, out_idx, exp_idx[b]);
            chk({tag, "_last"}, out_last, (b == k - 1) ? 1 : 0);
            chk({tag, "_none"}, out_none, 0);
            chk({tag, "_cnt"}, out_cnt, exp_cnt);
            chk({tag, "_busy"}, in_ready, 0);
            tick();
        end
        chk({tag, "_done_valid"}, out_valid, 0);
        chk({tag, "_done_ready"}, in_ready, 1);
    endtask

    logic [2:0] seq_a5 [8] = '{3'd0, 3'd2, 3'd5, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0};
    logic [2:0] seq_ff [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [2:0] seq_80 [8] = '{3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    logic [2:0] seq_0c [8] = '{3'd2, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    logic [2:0] seq_f0 [8] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0};

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = 8'h00;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_cnt", out_cnt, 0);
        chk("rst_out_idx", out_idx, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // Basic burst, 4 set bits, back to ready 5 cycles after acceptance.
        send(8'hA5);
        burst("a5", 4, seq_a5, 4'd4);

        // Backpressure on the second beat.
        send(8'h12);
        out_ready = 1'b1;
        chk("bp_idx0", out_idx, 1);
        chk("bp_last0", out_last, 0);
        tick();
        out_ready = 1'b0;
        chk("bp_idx1", out_idx, 4);
        chk("bp_last1", out_last, 1);
        tick();
        chk("bp_stall1_valid", out_valid, 1);
        chk("bp_stall1_idx", out_idx, 4);
        tick();
        chk("bp_stall2_idx", out_idx, 4);
        chk("bp_stall2_last", out_last, 1);
        chk("bp_stall2_cnt", out_cnt, 2);
        out_ready = 1'b1;
        tick();
        chk("bp_done_valid", out_valid, 0);
        chk("bp_done_ready", in_ready, 1);

        // All-zero vector versus bit 0 only.
        send(8'h00);
        chk("zero_valid", out_valid, 1);
        chk("zero_none", out_none, 1);
        chk("zero_last", out_last, 1);
        chk("zero_idx", out_idx, 0);
        chk("zero_cnt", out_cnt, 0);
        chk("zero_busy", in_ready, 0);
        tick();
        chk("zero_done_valid", out_valid, 0);
        chk("zero_done_ready", in_ready, 1);
        send(8'h01);
        chk("one_none", out_none, 0);
        chk("one_cnt", out_cnt, 1);
        chk("one_idx", out_idx, 0);
        chk("one_last", out_last, 1);
        tick();
        chk("one_done_ready", in_ready, 1);

        // Full and top-bit vectors.
        send(8'hFF);
        burst("ff", 8, seq_ff, 4'd8);
        send(8'h80);
        burst("80", 1, seq_80, 4'd1);

        // Input changes while busy are ignored; the held vector is taken at the next idle cycle.
        send(8'h0C);
        in_vec   = 8'hF0;
        in_valid = 1'b1;
        burst("0c", 2, seq_0c, 4'd2);
        tick();
        in_valid = 1'b0;
        burst("f0", 4, seq_f0, 4'd4);

        // Reset mid-burst drops everything without a clock edge.
        send(8'hA5);
        out_ready = 1'b1;
        chk("mid_idx0", out_idx, 0);
        tick();
        chk("mid_idx1", out_idx, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_idx", out_idx, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_cnt", out_cnt, 0);
        chk("mid_rst_ready", in_ready, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rel_ready", in_ready, 1);
        chk("mid_rel_valid", out_valid, 0);
        send(8'h80);
        burst("post_rst", 1, seq_80, 4'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
